// File: rtl/multicycle_control.sv
// Multicycle controller for an 11-bit RISC-V subset: R-type add/sub/and/or, lw, sw and beq.
// Handles memory handshakes, raises a sticky illegal flag and counts retired instructions.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] instruction,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IorD,
  output logic        ALUSrcA,
  output logic        MemtoReg,
  output logic        PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUOp,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [15:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_ADDR = 4'd3,
    S_EXEC_BEQ  = 4'd4,
    S_MEM_RD    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_WB_R      = 4'd7,
    S_WB_MEM    = 4'd8,
    S_ILLEGAL   = 4'd9
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  state_t      r_state;
  state_t      w_next;
  logic        r_illegal;
  logic [15:0] r_instr_count;

  logic       w_retire;
  logic       w_pcWrite, w_irWrite, w_memRead, w_memWrite, w_regWrite;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_alt;

  assign w_opcode = instruction[6:0];
  assign w_funct3 = instruction[9:7];
  assign w_alt    = instruction[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_instr_count <= 16'd0;
      r_illegal     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire)
        r_instr_count <= r_instr_count + 16'd1;
      if (w_next == S_ILLEGAL)
        r_illegal <= 1'b1;
    end
  end

  // w_retire marks the edge that completes an instruction; it feeds the counter only.
  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    w_pcWrite  = 1'b0;
    w_irWrite  = 1'b0;
    w_memRead  = 1'b0;
    w_memWrite = 1'b0;
    w_regWrite = 1'b0;
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    MemtoReg   = 1'b0;
    PCSource   = 1'b0;
    ALUSrcB    = 2'b00;
    ALUOp      = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_memRead = 1'b1;
        ALUSrcB   = 2'b01;
        w_irWrite = mem_ready;
        w_pcWrite = mem_ready;
        if (mem_ready)
          w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b10;
        case (w_opcode)
          OP_R:
            w_next = (w_funct3 == 3'b000 || w_funct3 == 3'b110 || w_funct3 == 3'b111)
                     ? S_EXEC_R : S_ILLEGAL;
          OP_LW, OP_SW: w_next = S_EXEC_ADDR;
          OP_BEQ:       w_next = S_EXEC_BEQ;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        case (w_funct3)
          3'b000:  ALUOp = w_alt ? ALU_SUB : ALU_ADD;
          3'b111:  ALUOp = ALU_AND;
          3'b110:  ALUOp = ALU_OR;
          default: ALUOp = ALU_ADD;
        endcase
        w_next = S_WB_R;
      end
      S_WB_R: begin
        w_regWrite = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_EXEC_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (w_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_memRead = 1'b1;
        IorD      = 1'b1;
        if (mem_ready)
          w_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        w_regWrite = 1'b1;
        MemtoReg   = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        w_memWrite = 1'b1;
        IorD       = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXEC_BEQ: begin
        ALUSrcA   = 1'b1;
        ALUOp     = ALU_SUB;
        PCSource  = 1'b1;
        w_pcWrite = zero;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_ILLEGAL: w_next = S_ILLEGAL;
      default:   w_next = S_FETCH;
    endcase
  end

  // Enables are gated by rst so an in-flight memory access is dropped in the reset cycle.
  assign PCWrite     = w_pcWrite  & ~rst;
  assign IRWrite     = w_irWrite  & ~rst;
  assign MemRead     = w_memRead  & ~rst;
  assign MemWrite    = w_memWrite & ~rst;
  assign RegWrite    = w_regWrite & ~rst;
  assign illegal     = r_illegal;
  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] AND = 4'b0000;
  localparam logic [3:0] OR  = 4'b0001;

  localparam logic [10:0] I_ADD  = {1'b0, 3'b000, 7'b0110011};
  localparam logic [10:0] I_SUB  = {1'b1, 3'b000, 7'b0110011};
  localparam logic [10:0] I_AND  = {1'b0, 3'b111, 7'b0110011};
  localparam logic [10:0] I_OR   = {1'b0, 3'b110, 7'b0110011};
  localparam logic [10:0] I_LW   = {1'b0, 3'b010, 7'b0000011};
  localparam logic [10:0] I_SW   = {1'b0, 3'b010, 7'b0100011};
  localparam logic [10:0] I_BEQ  = {1'b0, 3'b000, 7'b1100011};
  localparam logic [10:0] I_BAD  = {1'b0, 3'b000, 7'b1111111};
  localparam logic [10:0] I_BADR = {1'b1, 3'b010, 7'b0110011};

  // en = {PCWrite,IRWrite,MemRead,MemWrite,RegWrite}; sel = {IorD,ALUSrcA,MemtoReg,PCSource}
  typedef struct packed {
    logic [3:0]  st;
    logic [4:0]  en;
    logic [3:0]  sel;
    logic [1:0]  srcB;
    logic [3:0]  aluop;
    logic        ill;
    logic [15:0] cnt;
  } obs_t;

  logic        clk;
  logic        rst;
  logic [10:0] instruction;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
  logic        IorD, ALUSrcA, MemtoReg, PCSource;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUOp;
  logic        illegal;
  logic [3:0]  state;
  logic [15:0] instr_count;

  obs_t  expQ[$];
  string tagQ[$];
  int    nChecks = 0;
  int    nErrors = 0;

  multicycle_control dut (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IorD(IorD), .ALUSrcA(ALUSrcA), .MemtoReg(MemtoReg),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal(illegal),
    .state(state), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input obs_t e);
    obs_t a;
    a = '{st: state, en: {PCWrite, IRWrite, MemRead, MemWrite, RegWrite},
          sel: {IorD, ALUSrcA, MemtoReg, PCSource}, srcB: ALUSrcB, aluop: ALUOp,
          ill: illegal, cnt: instr_count};
    nChecks++;
    if (a !== e) begin
      nErrors++;
      $display("[TB] FAIL %s: got st=%0d en=%b sel=%b srcB=%b op=%b ill=%b cnt=%h, want st=%0d en=%b sel=%b srcB=%b op=%b ill=%b cnt=%h",
               tag, a.st, a.en, a.sel, a.srcB, a.aluop, a.ill, a.cnt,
               e.st, e.en, e.sel, e.srcB, e.aluop, e.ill, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0)
      checkOutput(tagQ.pop_front(), expQ.pop_front());
  end

  // One call = one clock cycle: drive inputs just after the edge and queue what that cycle must show.
  task automatic applyStimulus(input string tag, input logic r, input logic [10:0] ins,
                               input logic z, input logic mr, input logic [3:0] st,
                               input logic [4:0] en, input logic [3:0] sel, input logic [1:0] srcB,
                               input logic [3:0] op, input logic ill, input logic [15:0] cnt);
    @(posedge clk);
    #1;
    rst = r; instruction = ins; zero = z; mem_ready = mr;
    expQ.push_back('{st: st, en: en, sel: sel, srcB: srcB, aluop: op, ill: ill, cnt: cnt});
    tagQ.push_back(tag);
  endtask

  task automatic runRtype(input string tag, input logic [10:0] ins, input logic [3:0] op,
                          input logic mrLater, input logic [15:0] c);
    applyStimulus({tag, ".F"}, 0, ins, 0, 1,       4'd0, 5'b11100, 4'b0000, 2'b01, ADD, 0, c);
    applyStimulus({tag, ".D"}, 0, ins, 0, mrLater, 4'd1, 5'b00000, 4'b0000, 2'b10, ADD, 0, c);
    applyStimulus({tag, ".E"}, 0, ins, 0, mrLater, 4'd2, 5'b00000, 4'b0100, 2'b00, op,  0, c);
    applyStimulus({tag, ".W"}, 0, ins, 0, mrLater, 4'd7, 5'b00001, 4'b0000, 2'b00, ADD, 0, c);
  endtask

  task automatic runLoad(input string tag, input int stalls, input logic [15:0] c);
    applyStimulus({tag, ".F"}, 0, I_LW, 0, 1, 4'd0, 5'b11100, 4'b0000, 2'b01, ADD, 0, c);
    applyStimulus({tag, ".D"}, 0, I_LW, 0, 1, 4'd1, 5'b00000, 4'b0000, 2'b10, ADD, 0, c);
    applyStimulus({tag, ".A"}, 0, I_LW, 0, 1, 4'd3, 5'b00000, 4'b0100, 2'b10, ADD, 0, c);
    for (int i = 0; i < stalls; i++)
      applyStimulus({tag, ".Mwait"}, 0, I_LW, 0, 0, 4'd5, 5'b00100, 4'b1000, 2'b00, ADD, 0, c);
    applyStimulus({tag, ".M"}, 0, I_LW, 0, 1, 4'd5, 5'b00100, 4'b1000, 2'b00, ADD, 0, c);
    applyStimulus({tag, ".W"}, 0, I_LW, 0, 0, 4'd8, 5'b00001, 4'b0010, 2'b00, ADD, 0, c);
  endtask

  task automatic runStoreHead(input string tag, input logic [15:0] c);
    applyStimulus({tag, ".F"}, 0, I_SW, 0, 1, 4'd0, 5'b11100, 4'b0000, 2'b01, ADD, 0, c);
    applyStimulus({tag, ".D"}, 0, I_SW, 0, 1, 4'd1, 5'b00000, 4'b0000, 2'b10, ADD, 0, c);
    applyStimulus({tag, ".A"}, 0, I_SW, 0, 1, 4'd3, 5'b00000, 4'b0100, 2'b10, ADD, 0, c);
    applyStimulus({tag, ".Mwait"}, 0, I_SW, 0, 0, 4'd6, 5'b00010, 4'b1000, 2'b00, ADD, 0, c);
  endtask

  task automatic runBeq(input string tag, input logic z, input logic [15:0] c);
    applyStimulus({tag, ".F"}, 0, I_BEQ, z, 1, 4'd0, 5'b11100, 4'b0000, 2'b01, ADD, 0, c);
    applyStimulus({tag, ".D"}, 0, I_BEQ, z, 1, 4'd1, 5'b00000, 4'b0000, 2'b10, ADD, 0, c);
    applyStimulus({tag, ".B"}, 0, I_BEQ, z, 1, 4'd4, {z, 4'b0000}, 4'b0101, 2'b00, SUB, 0, c);
  endtask

  task automatic resetCycle(input string tag, input logic [3:0] st, input logic ill,
                            input logic [15:0] cnt);
    if (st == 4'd0)
      applyStimulus(tag, 1, I_ADD, 0, 1, st, 5'b00000, 4'b0000, 2'b01, ADD, ill, cnt);
    else
      applyStimulus(tag, 1, I_ADD, 0, 1, st, 5'b00000, 4'b0000, 2'b00, ADD, ill, cnt);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; instruction = I_ADD; zero = 1'b0; mem_ready = 1'b1;

    resetCycle("rst0", 4'd0, 0, 16'h0000);
    resetCycle("rst1", 4'd0, 0, 16'h0000);
    applyStimulus("fetchStall", 0, I_ADD, 0, 0, 4'd0, 5'b00100, 4'b0000, 2'b01, ADD, 0, 16'h0000);

    runRtype("add", I_ADD, ADD, 1, 16'h0000);
    runRtype("sub", I_SUB, SUB, 1, 16'h0001);
    runRtype("and", I_AND, AND, 1, 16'h0002);
    runRtype("or",  I_OR,  OR,  0, 16'h0003);

    runLoad("lw", 3, 16'h0004);

    runStoreHead("sw", 16'h0005);
    applyStimulus("sw.M", 0, I_SW, 0, 1, 4'd6, 5'b00010, 4'b1000, 2'b00, ADD, 0, 16'h0005);

    runBeq("beqT", 1, 16'h0006);
    runBeq("beqN", 0, 16'h0007);

    // Store interrupted by reset: the write drops in the reset cycle and is never counted.
    runStoreHead("swRst", 16'h0008);
    applyStimulus("swRst.rst", 1, I_SW, 0, 1, 4'd6, 5'b00000, 4'b1000, 2'b00, ADD, 0, 16'h0008);
    applyStimulus("swRst.after", 0, I_SW, 0, 0, 4'd0, 5'b00100, 4'b0000, 2'b01, ADD, 0, 16'h0000);

    applyStimulus("bad.F", 0, I_BAD, 0, 1, 4'd0, 5'b11100, 4'b0000, 2'b01, ADD, 0, 16'h0000);
    applyStimulus("bad.D", 0, I_BAD, 0, 1, 4'd1, 5'b00000, 4'b0000, 2'b10, ADD, 0, 16'h0000);
    for (int i = 0; i < 20; i++)
      applyStimulus("bad.hold", 0, I_ADD, i[0], i[0], 4'd9, 5'b00000, 4'b0000, 2'b00, ADD, 1, 16'h0000);
    resetCycle("bad.rst", 4'd9, 1, 16'h0000);
    applyStimulus("bad.after", 0, I_BADR, 0, 1, 4'd0, 5'b11100, 4'b0000, 2'b01, ADD, 0, 16'h0000);

    applyStimulus("badR.D", 0, I_BADR, 0, 1, 4'd1, 5'b00000, 4'b0000, 2'b10, ADD, 0, 16'h0000);
    for (int i = 0; i < 3; i++)
      applyStimulus("badR.hold", 0, I_BADR, 0, 1, 4'd9, 5'b00000, 4'b0000, 2'b00, ADD, 1, 16'h0000);
    resetCycle("badR.rst", 4'd9, 1, 16'h0000);
    applyStimulus("badR.after", 0, I_BEQ, 0, 0, 4'd0, 5'b00100, 4'b0000, 2'b01, ADD, 0, 16'h0000);

    // Counter wrap: preload near the top rather than retiring 65534 instructions.
    @(posedge clk);
    #1;
    force dut.r_instr_count = 16'hFFFE;
    #1;
    release dut.r_instr_count;
    runBeq("wrapA", 0, 16'hFFFE);
    runBeq("wrapB", 1, 16'hFFFF);
    applyStimulus("wrap.after", 0, I_BEQ, 0, 0, 4'd0, 5'b00100, 4'b0000, 2'b01, ADD, 0, 16'h0000);

    for (int i = 0; i < 5 && expQ.size() > 0; i++)
      @(posedge clk);
    if (expQ.size() > 0) begin
      nErrors++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
